caravel_hyperspace: RTL and testbench

Pad-level streaming compute block for the HyperSpace user project inside the Caravel harness. It receives an 8-bit valid/ready byte stream on user GPIO pads, groups bytes in fours, and emits three 16-bit adjacent-pair products per group on a 16-bit valid/ready output stream. A full 2048-byte frame therefore yields 1536 output words. The block sits directly behind the `mprj_io` pads; it has no Wishbone or logic-analyzer interface.

---
 rtl/hyperspace_pkg.sv | 24 ++
 rtl/hyperspace_core.sv | 98 +++++++++
 rtl/caravel_hyperspace.sv | 59 +++++
 tb/tb_caravel_hyperspace.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperspace_pkg.sv
// Shared constants for the HyperSpace pad-level stream engine:
// pad bit positions, group sizes and the engine state type.
package hyperspace_pkg;

    localparam int unsigned IN_DATA_MSB  = 37;
    localparam int unsigned IN_DATA_LSB  = 30;
    localparam int unsigned IN_LAST      = 29;
    localparam int unsigned IN_VALID     = 28;
    localparam int unsigned IN_READY     = 27;
    localparam int unsigned OUT_READY    = 18;
    localparam int unsigned OUT_VALID    = 17;
    localparam int unsigned OUT_LAST     = 16;
    localparam int unsigned OUT_DATA_MSB = 15;
    localparam int unsigned OUT_DATA_LSB = 0;

    localparam int unsigned GROUP_IN  = 4;
    localparam int unsigned GROUP_OUT = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

endpackage

// File: rtl/hyperspace_core.sv
// Stream engine: collects byte groups of four and emits the three
// adjacent-pair products of each group.
module hyperspace_core
    import hyperspace_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic [OUT_W-1:0] out_data_o
);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      k_q, k_d;
    logic            last_q, last_d;
    logic [IN_W-1:0] buf_q [GROUP_IN];
    logic [IN_W-1:0] buf_d [GROUP_IN];
    logic [IN_W-1:0] op_a, op_b;
    logic [OUT_W-1:0] product;

    always_comb begin
        op_a    = buf_q[k_q];
        op_b    = buf_q[k_q + 2'd1];
        product = OUT_W'(op_a) * OUT_W'(op_b);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        last_d      = last_q;
        buf_d       = buf_q;
        in_ready_o  = (state_q == COLLECT);
        out_valid_o = (state_q == EMIT);
        out_data_o  = '0;
        out_last_o  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_valid_i) begin
                    buf_d[idx_q] = in_data_i;
                    if (in_last_i) last_d = 1'b1;
                    if (idx_q == 2'(GROUP_IN - 1) || in_last_i) begin
                        // An early last zero-pads the slots above the closing byte.
                        for (int unsigned i = 0; i < GROUP_IN; i++) begin
                            if (2'(i) > idx_q) buf_d[2'(i)] = '0;
                        end
                        state_d = EMIT;
                        k_d     = 2'd0;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            EMIT: begin
                out_data_o = product;
                out_last_o = (k_q == 2'(GROUP_OUT - 1)) && last_q;
                if (out_ready_i) begin
                    if (k_q == 2'(GROUP_OUT - 1)) begin
                        state_d = COLLECT;
                        k_d     = 2'd0;
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: rtl/caravel_hyperspace.sv
// Caravel user-project top: maps mprj_io pads onto the stream engine
// and drives a constant output-enable pattern.
module caravel_hyperspace
    import hyperspace_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic [OUT_W-1:0] out_data;
    logic             unused_pads;

    // Pad order is reversed: in_data[i] sits on io_in[37-i].
    assign in_data     = {<<{io_in[IN_DATA_MSB:IN_DATA_LSB]}};
    assign unused_pads = ^{io_in[IN_READY:OUT_READY+1], io_in[OUT_VALID:0]};

    hyperspace_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .in_valid_i  (io_in[IN_VALID]),
        .in_data_i   (in_data),
        .in_last_i   (io_in[IN_LAST]),
        .in_ready_o  (in_ready),
        .out_ready_i (io_in[OUT_READY]),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .out_data_o  (out_data)
    );

    always_comb begin
        io_out                            = '0;
        io_out[IN_READY]                  = in_ready;
        io_out[OUT_VALID]                 = out_valid;
        io_out[OUT_LAST]                  = out_last;
        io_out[OUT_DATA_MSB:OUT_DATA_LSB] = out_data;
    end

    always_comb begin
        io_oeb                            = '1;
        io_oeb[IN_READY]                  = 1'b0;
        io_oeb[OUT_VALID]                 = 1'b0;
        io_oeb[OUT_LAST]                  = 1'b0;
        io_oeb[OUT_DATA_MSB:OUT_DATA_LSB] = '0;
    end

endmodule

// File: tb/tb_caravel_hyperspace.sv
// Self-checking bench for caravel_hyperspace: directed groups, backpressure,
// reset abort and random streams against a group-level reference model.
module tb_caravel_hyperspace;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int errors = 0;
    int checks = 0;

    logic [7:0]  in_b[$];
    bit          in_l[$];
    logic [15:0] obs_d[$];
    bit          obs_l[$];
    logic [15:0] exp_d[$];
    bit          exp_l[$];

    always #5 clk = ~clk;

    caravel_hyperspace #(
        .IN_W  (8),
        .OUT_W (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    task automatic set_in(input bit v, input logic [7:0] d, input bit l, input bit r);
        logic [37:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[37-i] = d[i];
        p[29] = l;
        p[28] = v;
        p[18] = r;
        io_in = p;
    endtask

    // Reference: split the byte list into groups closed by a 4th byte or a
    // last flag, pad with zeros, emit the three adjacent products.
    task automatic build_model();
        logic [7:0] g[4];
        int c;
        c = 0;
        exp_d.delete();
        exp_l.delete();
        foreach (in_b[j]) begin
            g[c] = in_b[j];
            c++;
            if (c == 4 || in_l[j]) begin
                for (int m = c; m < 4; m++) g[m] = 8'h00;
                for (int m = 0; m < 3; m++) begin
                    exp_d.push_back(16'(g[m]) * 16'(g[m+1]));
                    exp_l.push_back(m == 2 && in_l[j]);
                end
                c = 0;
            end
        end
    endtask

    task automatic run_stream(input bit rnd, input int budget, output int cyc);
        int bi;
        int n;
        int exp_n;
        bit v;
        bit r;
        bi = 0;
        n = in_b.size();
        build_model();
        exp_n = exp_d.size();
        obs_d.delete();
        obs_l.delete();
        cyc = 0;
        while ((bi < n || obs_d.size() < exp_n) && cyc < budget) begin
            @(negedge clk);
            r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            v = (bi < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (v) set_in(1'b1, in_b[bi], in_l[bi], r);
            else   set_in(1'b0, 8'h00, 1'b0, r);
            if (io_out[17] && r) begin
                obs_d.push_back(io_out[15:0]);
                obs_l.push_back(io_out[16]);
            end
            if (v && io_out[27]) bi++;
            cyc++;
        end
        @(negedge clk);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [37:0] exp_oeb;
        logic [37:0] exp_out;
        exp_oeb = '1;
        exp_oeb[27] = 1'b0;
        exp_oeb[17:0] = 18'h0;
        exp_oeb[18] = 1'b1;
        exp_out = 38'(1) << 27;
        rst = 1'b1;
        set_in(1'b1, 8'h5A, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (io_out !== exp_out) begin
            errors++;
            $display("FAIL reset io_out: got %h want %h", io_out, exp_out);
        end
        checks++;
        if (io_oeb !== exp_oeb) begin
            errors++;
            $display("FAIL reset io_oeb: got %h want %h", io_oeb, exp_oeb);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io_oeb !== exp_oeb) begin
            errors++;
            $display("FAIL oeb after reset: got %h want %h", io_oeb, exp_oeb);
        end
    endtask

    task automatic test_basic();
        logic [15:0] want[3];
        bit          wl[3];
        int cyc;
        want = '{16'h0006, 16'h000C, 16'h0014};
        wl   = '{1'b0, 1'b0, 1'b1};
        in_b = '{8'h02, 8'h03, 8'h04, 8'h05};
        in_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(1'b0, 50, cyc);
        checks++;
        if (obs_d.size() != 3) begin
            errors++;
            $display("FAIL basic count: got %0d want 3", obs_d.size());
        end
        for (int j = 0; j < 3 && j < obs_d.size(); j++) begin
            checks++;
            if (obs_d[j] !== want[j] || obs_l[j] !== wl[j]) begin
                errors++;
                $display("FAIL basic word %0d: got %h/%b want %h/%b", j, obs_d[j], obs_l[j], want[j], wl[j]);
            end
        end
    endtask

    task automatic test_max();
        int cyc;
        in_b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        in_l = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_stream(1'b0, 50, cyc);
        checks++;
        if (obs_d.size() != 3) begin
            errors++;
            $display("FAIL max count: got %0d want 3", obs_d.size());
        end
        for (int j = 0; j < 3 && j < obs_d.size(); j++) begin
            checks++;
            if (obs_d[j] !== 16'hFE01 || obs_l[j] !== 1'b0) begin
                errors++;
                $display("FAIL max word %0d: got %h/%b want fe01/0", j, obs_d[j], obs_l[j]);
            end
        end
    endtask

    task automatic test_short();
        logic [15:0] want[3];
        int cyc;
        want = '{16'h0200, 16'h0000, 16'h0000};
        in_b = '{8'h10, 8'h20};
        in_l = '{1'b0, 1'b1};
        run_stream(1'b0, 50, cyc);
        checks++;
        if (obs_d.size() != 3) begin
            errors++;
            $display("FAIL short count: got %0d want 3", obs_d.size());
        end
        for (int j = 0; j < 3 && j < obs_d.size(); j++) begin
            checks++;
            if (obs_d[j] !== want[j] || obs_l[j] !== (j == 2)) begin
                errors++;
                $display("FAIL short word %0d: got %h/%b want %h/%b", j, obs_d[j], obs_l[j], want[j], j == 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  b[4];
        logic [15:0] want[3];
        logic [15:0] held;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(1, 255));
        for (int m = 0; m < 3; m++) want[m] = 16'(b[m]) * 16'(b[m+1]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (io_out[27] !== 1'b1) begin
                errors++;
                $display("FAIL bp in_ready byte %0d: got %b want 1", i, io_out[27]);
            end
            set_in(1'b1, b[i], 1'b0, 1'b0);
        end
        @(negedge clk);
        held = io_out[15:0];
        checks++;
        if (io_out[17] !== 1'b1 || io_out[27] !== 1'b0 || held !== want[0]) begin
            errors++;
            $display("FAIL bp latency: got v=%b r=%b d=%h want v=1 r=0 d=%h", io_out[17], io_out[27], held, want[0]);
        end
        set_in(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (io_out[15:0] !== held || io_out[17] !== 1'b1 || io_out[27] !== 1'b0) begin
                errors++;
                $display("FAIL bp hold: got d=%h v=%b r=%b want d=%h v=1 r=0", io_out[15:0], io_out[17], io_out[27], held);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (io_out[15:0] !== want[k] || io_out[17] !== 1'b1 || io_out[16] !== 1'b0) begin
                errors++;
                $display("FAIL bp word %0d: got %h/%b/%b want %h/1/0", k, io_out[15:0], io_out[17], io_out[16], want[k]);
            end
            set_in(1'b0, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
        end
        checks++;
        if (io_out[27] !== 1'b1 || io_out[17] !== 1'b0 || io_out[16] !== 1'b0 || io_out[15:0] !== 16'h0) begin
            errors++;
            $display("FAIL bp return: got r=%b v=%b l=%b d=%h want 1/0/0/0000", io_out[27], io_out[17], io_out[16], io_out[15:0]);
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random_handshake();
        int cyc;
        in_b.delete();
        in_l.delete();
        for (int i = 0; i < 64; i++) begin
            in_b.push_back(8'($urandom));
            in_l.push_back(i == 63 || $urandom_range(0, 5) == 0);
        end
        run_stream(1'b1, 2000, cyc);
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL random count: got %0d want %0d", obs_d.size(), exp_d.size());
        end
        for (int j = 0; j < exp_d.size() && j < obs_d.size(); j++) begin
            checks++;
            if (obs_d[j] !== exp_d[j] || obs_l[j] !== exp_l[j]) begin
                errors++;
                $display("FAIL random word %0d: got %h/%b want %h/%b", j, obs_d[j], obs_l[j], exp_d[j], exp_l[j]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        @(negedge clk);
        set_in(1'b1, 8'h11, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b1, 8'h22, 1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (io_out !== (38'(1) << 27)) begin
            errors++;
            $display("FAIL abort collect: got %h want %h", io_out, 38'(1) << 27);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (io_out !== (38'(1) << 27)) begin
            errors++;
            $display("FAIL abort emit: got %h want %h", io_out, 38'(1) << 27);
        end
        rst = 1'b0;
        in_b = '{8'h33, 8'h44, 8'h55, 8'h66};
        in_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(1'b0, 50, cyc);
        checks++;
        if (obs_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL abort count: got %0d want %0d", obs_d.size(), exp_d.size());
        end
        for (int j = 0; j < exp_d.size() && j < obs_d.size(); j++) begin
            checks++;
            if (obs_d[j] !== exp_d[j] || obs_l[j] !== exp_l[j]) begin
                errors++;
                $display("FAIL abort word %0d: got %h/%b want %h/%b", j, obs_d[j], obs_l[j], exp_d[j], exp_l[j]);
            end
        end
    endtask

    task automatic test_full_frame();
        int cyc;
        int nlast;
        in_b.delete();
        in_l.delete();
        for (int i = 0; i < 2048; i++) begin
            in_b.push_back(8'($urandom));
            in_l.push_back(i == 2047);
        end
        run_stream(1'b0, 3600, cyc);
        checks++;
        if (obs_d.size() != 1536 || exp_d.size() != 1536) begin
            errors++;
            $display("FAIL frame count: got %0d want 1536", obs_d.size());
        end
        checks++;
        if (cyc > 3600) begin
            errors++;
            $display("FAIL frame cycles: got %0d want <= 3600", cyc);
        end
        nlast = 0;
        for (int j = 0; j < exp_d.size() && j < obs_d.size(); j++) begin
            if (obs_l[j]) nlast++;
            checks++;
            if (obs_d[j] !== exp_d[j] || obs_l[j] !== exp_l[j]) begin
                errors++;
                $display("FAIL frame word %0d: got %h/%b want %h/%b", j, obs_d[j], obs_l[j], exp_d[j], exp_l[j]);
            end
        end
        checks++;
        if (nlast != 1) begin
            errors++;
            $display("FAIL frame last count: got %0d want 1", nlast);
        end
    endtask

    initial begin
        io_in = '0;
        rst   = 1'b1;
        test_reset();
        test_basic();
        test_max();
        test_short();
        test_backpressure();
        test_random_handshake();
        test_reset_abort();
        test_full_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
